// File: rtl/regfile_write_arbiter.sv
// Two-source writeback arbiter for the single register-file write port.
// Each source has a one-entry holding register; entries drain round-robin, oldest-first on same destination.
module regfile_write_arbiter #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter bit ZERO_DROP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,

    output logic              rf_regWrite,
    output logic [ADDR_W-1:0] rf_writeReg,
    output logic [DATA_W-1:0] rf_writeData,

    input  logic [ADDR_W-1:0] query_addr,
    output logic              query_pending
);

    logic              full0, full1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] data0, data1;
    logic              older;       // 1: entry 1 holds the older write
    logic              lastGrant;

    logic grant0, grant1;
    logic acc0, acc1;
    logic keep0, keep1;
    logic hit0, hit1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (full0 && full1) begin
            if (addr0 == addr1) begin
                grant0 = ~older;
                grant1 = older;
            end else begin
                grant0 = lastGrant;
                grant1 = ~lastGrant;
            end
        end else begin
            grant0 = full0;
            grant1 = full1;
        end
    end

    // An entry draining this cycle can take a new write at the same edge.
    assign req0_ready = ~rst & (~full0 | grant0);
    assign req1_ready = ~rst & (~full1 | grant1);

    assign acc0  = req0_valid & req0_ready;
    assign acc1  = req1_valid & req1_ready;
    assign keep0 = acc0 & ~(ZERO_DROP && (req0_addr == '0));
    assign keep1 = acc1 & ~(ZERO_DROP && (req1_addr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full0     <= 1'b0;
            full1     <= 1'b0;
            addr0     <= '0;
            addr1     <= '0;
            data0     <= '0;
            data1     <= '0;
            older     <= 1'b0;
            lastGrant <= 1'b1;
        end else begin
            full0 <= keep0 | (full0 & ~grant0);
            full1 <= keep1 | (full1 & ~grant1);
            if (keep0) begin
                addr0 <= req0_addr;
                data0 <= req0_data;
            end
            if (keep1) begin
                addr1 <= req1_addr;
                data1 <= req1_data;
            end
            if (grant0 || grant1)
                lastGrant <= grant1;
            // Simultaneous accepts leave source 0 older so source 1 lands last.
            if (acc0 && acc1)
                older <= 1'b0;
            else if (acc0)
                older <= 1'b1;
            else if (acc1)
                older <= 1'b0;
        end
    end

    always_comb begin
        rf_regWrite  = ~rst & (grant0 | grant1);
        rf_writeReg  = '0;
        rf_writeData = '0;
        if (grant0) begin
            rf_writeReg  = addr0;
            rf_writeData = data0;
        end else if (grant1) begin
            rf_writeReg  = addr1;
            rf_writeData = data1;
        end
    end

    assign hit0          = full0 & (addr0 == query_addr);
    assign hit1          = full1 & (addr1 == query_addr);
    assign query_pending = ~rst & (query_addr != '0) & (hit0 | hit1);

endmodule
